snake_body_buffer: RTL and testbench
====================================

# snake_body_buffer

Clocked, parametrised store for the snake's body segment positions: a circular buffer where index 0 is always the head and index len-1 is the tail. Replaces the flat tail array with O(1) move/grow updates, a registered random-read port for the renderer, and a built-in sequential collision scanner. It sits between the game-logic FSM, which issues steps and collision queries, and the VGA drawing logic, which issues reads.

## Interface
- POS_W, 12, width of one position word (packed x/y)
- DEPTH, 128, maximum segment count; must be a power of two
- ADDR_W, 7, log2(DEPTH)

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- init  in  1  synchronous clear: length becomes 1, head becomes init_pos
- init_pos  in  POS_W  head position loaded by init
- step_valid  in  1  request to move the snake one cell
- step_grow  in  1  qualifies step: 1 = grow (tail kept), 0 = move (tail dropped)
- step_pos  in  POS_W  new head position
- step_ready  out  1  step accepted on an edge where step_valid && step_ready
- rd_en  in  1  read request
- rd_idx  in  ADDR_W  segment index, 0 = head
- rd_data  out  POS_W  read result
- rd_valid  out  1  rd_data is valid this cycle
- len  out  ADDR_W+1  current segment count, range 1..DEPTH
- head_pos  out  POS_W  registered copy of segment 0
- full  out  1  len == DEPTH
- scan_start  in  1  start a collision query
- scan_pos  in  POS_W  position to search for
- scan_skip_head  in  1  exclude index 0 from the search
- scan_busy  out  1  scanner active
- scan_done  out  1  one-cycle pulse when the query completes
- scan_hit  out  1  query result; held until the next scan_start or init

## Operation
- Storage: DEPTH x POS_W array plus head pointer h. Index i maps to address (h - i) mod DEPTH; wrap is natural modulo-2^ADDR_W arithmetic. The array is not reset.
- Reset values: len=1, h=0, head_pos=0, full=0, rd_data=0, rd_valid=0, step_ready=1, scan_busy=0, scan_done=0, scan_hit=0.
- Priority on each edge: init, then step, then scan_start.
- init:
  - Writes init_pos at h, sets len=1 and head_pos=init_pos.
  - Aborts any scan: the scanner goes to IDLE, scan_done is not pulsed, scan_hit is cleared.
- step, accepted when step_valid && step_ready:
  - h <= h+1 and mem[h+1] <= step_pos; head_pos <= step_pos.
  - Grow: len <= len+1.
  - Move: len is unchanged and the old tail is dropped implicitly.
  - Grow while full behaves as move: len saturates at DEPTH and full stays 1.
- step_ready = !scan_busy && !init.
- Read port:
  - Independent of the scanner; remains usable during a scan.
  - rd_idx >= len returns rd_data=0.
  - A read issued in the same cycle as a step sees the pre-step contents.
- Scanner FSM:
  - IDLE: scan_start with !init -> capture scan_pos, set the start index (1 if scan_skip_head, else 0), go to SCAN.
  - SCAN: issue one read per cycle. The compare runs one cycle behind the read. On a match, set scan_hit=1 and go to DONE. When the last index (len-1) has been compared with no match, go to DONE with scan_hit=0.
  - DONE: pulse scan_done for one cycle, then go to IDLE.
  - Empty range (len=1 with skip_head): go straight to DONE, scan_hit=0.
  - scan_start while busy is ignored.
- Length cannot change during a scan because steps are blocked.

## Timing
- Step: visible on len, head_pos and full one cycle after the accepting edge.
- Read: rd_en sampled at edge k gives rd_data/rd_valid valid during cycle k+1; rd_valid=0 otherwise.
- Scan: with M = number of entries compared (including a matching one), scan_done asserts M+2 cycles after the scan_start edge. An empty range completes in 2 cycles.
- scan_busy: high from the cycle after the start edge through the scan_done cycle.
- reset_n low at any time returns all outputs to their reset values asynchronously; an in-flight scan or read is discarded.

## Configuration
- SNAKE_BUF_SCAN_EN
  - Defined: the scanner is built as described above.
  - Undefined: no scanner logic is built. scan_busy, scan_done and scan_hit are tied to 0, scan_start is ignored, and step_ready = !init.

## Test plan
- Reset, then init with init_pos=12'h123 -> len=1, head_pos=12'h123; reading idx 0 gives 12'h123 one cycle later, and reading idx 1 gives 0.
- From len=1, three grow steps with positions 1, 2, 3 -> len=4; reads of idx 0..3 return 3, 2, 1, 12'h123.
- With len=4, move step to 4 -> len=4; idx 3 returns 1 (tail dropped).
- Fill to DEPTH=128 with grows, then 200 further grows -> full=1, len=128, h wraps; idx 127 returns the value written 127 steps earlier.
- Scan with len=4, scan_pos equal to the idx 2 entry, skip_head=1 -> hit=1, done 4 cycles after start, step_ready=0 while busy. Repeat with an absent value -> hit=0, done 5 cycles after start.
- init asserted mid-scan -> scan_busy drops the next cycle, no scan_done pulse, scan_hit=0, len=1.

Source files
------------

// File: rtl/snake_body_buffer_if.sv
// snake_body_buffer_if
// Bundles the three transaction groups of the snake body buffer: step
// (move/grow), renderer read port and collision scan. The game logic and the
// VGA renderer sit on the master side; the buffer itself is the slave.
interface snake_body_buffer_if #(
    parameter int POS_W  = 12,
    parameter int ADDR_W = 7
);

    // Step channel: one new head position per accepted handshake
    logic              step_valid;
    logic              step_grow;
    logic [POS_W-1:0]  step_pos;
    logic              step_ready;

    // Registered random-read port used by the renderer
    logic              rd_en;
    logic [ADDR_W-1:0] rd_idx;
    logic [POS_W-1:0]  rd_data;
    logic              rd_valid;

    // Sequential collision query
    logic              scan_start;
    logic [POS_W-1:0]  scan_pos;
    logic              scan_skip_head;
    logic              scan_busy;
    logic              scan_done;
    logic              scan_hit;

    modport master (
        output step_valid,
        output step_grow,
        output step_pos,
        input  step_ready,
        output rd_en,
        output rd_idx,
        input  rd_data,
        input  rd_valid,
        output scan_start,
        output scan_pos,
        output scan_skip_head,
        input  scan_busy,
        input  scan_done,
        input  scan_hit
    );

    modport slave (
        input  step_valid,
        input  step_grow,
        input  step_pos,
        output step_ready,
        input  rd_en,
        input  rd_idx,
        output rd_data,
        output rd_valid,
        input  scan_start,
        input  scan_pos,
        input  scan_skip_head,
        output scan_busy,
        output scan_done,
        output scan_hit
    );

endinterface

// File: rtl/snake_body_buffer.sv
// snake_body_buffer
// Circular store of snake segment positions. Index 0 is the head, index
// len-1 the tail; segment i lives at address (head_ptr - i) mod DEPTH, so a
// move or grow only advances the head pointer and writes one word.
// Optional feature macro: SNAKE_BUF_SCAN_EN builds the sequential collision
// scanner. Without it the scan outputs are tied low and scan_start is ignored.
module snake_body_buffer #(
    parameter int POS_W  = 12,
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               init,
    input  logic [POS_W-1:0]   init_pos,
    snake_body_buffer_if.slave bus,
    output logic [ADDR_W:0]    len,
    output logic [POS_W-1:0]   head_pos,
    output logic               full
);

    localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   LEN_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

    logic [POS_W-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] head_ptr;
    logic [ADDR_W-1:0] head_next;
    logic              step_accept;
    logic              scan_busy_int;

    logic [ADDR_W-1:0] rd_addr;
    logic              rd_in_range;

    assign head_next   = head_ptr + PTR_ONE;
    assign step_accept = bus.step_valid && bus.step_ready && !init;
    assign full        = (len == LEN_DEPTH);

    // Steps are refused while a clear is pending or a scan is walking the body
    assign bus.step_ready = !scan_busy_int && !init;

    // Single write port: init overwrites the current head slot, a step writes the next slot
    always_ff @(posedge clk) begin
        if (init) begin
            mem[head_ptr] <= init_pos;
        end else if (step_accept) begin
            mem[head_next] <= bus.step_pos;
        end
    end

    // Head pointer, length and head copy; grow saturates at DEPTH so a full snake just moves
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_ptr <= '0;
            len      <= LEN_ONE;
            head_pos <= '0;
        end else if (init) begin
            len      <= LEN_ONE;
            head_pos <= init_pos;
        end else if (step_accept) begin
            head_ptr <= head_next;
            head_pos <= bus.step_pos;
            if (bus.step_grow && (len != LEN_DEPTH)) begin
                len <= len + LEN_ONE;
            end
        end
    end

    assign rd_addr     = head_ptr - bus.rd_idx;
    assign rd_in_range = ({1'b0, bus.rd_idx} < len);

    // Renderer read port: registered, sees pre-step contents, returns 0 beyond the tail
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.rd_data  <= '0;
            bus.rd_valid <= 1'b0;
        end else begin
            bus.rd_valid <= bus.rd_en;
            if (bus.rd_en && rd_in_range) begin
                bus.rd_data <= mem[rd_addr];
            end else begin
                bus.rd_data <= '0;
            end
        end
    end

`ifdef SNAKE_BUF_SCAN_EN

    typedef enum logic [1:0] {
        SCAN_IDLE,
        SCAN_RUN,
        SCAN_DONE
    } scan_state_e;

    scan_state_e       scan_state;
    scan_state_e       scan_state_next;
    logic [ADDR_W:0]   scan_idx;
    logic [POS_W-1:0]  scan_key;
    logic [POS_W-1:0]  cmp_data;
    logic              cmp_valid;
    logic              cmp_last;
    logic              scan_issue;
    logic              scan_accept;
    logic              scan_hit_set;
    logic              scan_hit_q;
    logic [ADDR_W-1:0] scan_addr;

    assign scan_addr     = head_ptr - scan_idx[ADDR_W-1:0];
    assign scan_busy_int = (scan_state != SCAN_IDLE);

    assign bus.scan_busy = scan_busy_int;
    assign bus.scan_done = (scan_state == SCAN_DONE);
    assign bus.scan_hit  = scan_hit_q;

    // Scanner next state: reads run one index per cycle, the compare trails one cycle behind;
    // a step accepted on the same edge wins over a new query so length never shifts under it
    always_comb begin
        scan_state_next = scan_state;
        scan_issue      = 1'b0;
        scan_accept     = 1'b0;
        scan_hit_set    = 1'b0;
        case (scan_state)
            SCAN_IDLE: begin
                if (bus.scan_start && !init && !step_accept) begin
                    scan_accept     = 1'b1;
                    scan_state_next = SCAN_RUN;
                end
            end
            SCAN_RUN: begin
                scan_issue = (scan_idx < len);
                if (cmp_valid && (cmp_data == scan_key)) begin
                    scan_hit_set    = 1'b1;
                    scan_state_next = SCAN_DONE;
                end else if (cmp_valid && cmp_last) begin
                    scan_state_next = SCAN_DONE;
                end else if (!cmp_valid && !scan_issue) begin
                    scan_state_next = SCAN_DONE;
                end
            end
            SCAN_DONE: begin
                scan_state_next = SCAN_IDLE;
            end
            default: begin
                scan_state_next = SCAN_IDLE;
            end
        endcase
        if (init) begin
            scan_state_next = SCAN_IDLE;
        end
    end

    // Scanner state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_state <= SCAN_IDLE;
        end else begin
            scan_state <= scan_state_next;
        end
    end

    // Scanner datapath: query capture, read pipeline stage and the held hit flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_idx   <= '0;
            scan_key   <= '0;
            cmp_data   <= '0;
            cmp_valid  <= 1'b0;
            cmp_last   <= 1'b0;
            scan_hit_q <= 1'b0;
        end else begin
            cmp_valid <= scan_issue && !init;
            if (scan_issue) begin
                cmp_data <= mem[scan_addr];
                cmp_last <= (scan_idx == (len - LEN_ONE));
                scan_idx <= scan_idx + LEN_ONE;
            end
            if (scan_accept) begin
                scan_key <= bus.scan_pos;
                scan_idx <= bus.scan_skip_head ? LEN_ONE : '0;
            end
            if (init || scan_accept) begin
                scan_hit_q <= 1'b0;
            end else if (scan_hit_set) begin
                scan_hit_q <= 1'b1;
            end
        end
    end

`else

    logic unused_scan_inputs;

    assign unused_scan_inputs = ^{bus.scan_start, bus.scan_pos, bus.scan_skip_head};
    assign scan_busy_int      = 1'b0;
    assign bus.scan_busy      = 1'b0;
    assign bus.scan_done      = 1'b0;
    assign bus.scan_hit       = 1'b0;

`endif

endmodule

// File: tb/tb_snake_body_buffer.sv
// tb_snake_body_buffer
// Table of step/read vectors with constant expectations, a queue model of
// the body (front = head) for long sequences, and a read scoreboard keyed by
// the cycle in which rd_valid must appear. Scanner sequences are compiled
// when SNAKE_BUF_SCAN_EN is defined; otherwise the tied-off outputs are checked.
module tb_snake_body_buffer;

    localparam int POS_W  = 12;
    localparam int DEPTH  = 128;
    localparam int ADDR_W = 7;

    logic              clk;
    logic              reset_n;
    logic              init;
    logic [POS_W-1:0]  init_pos;
    logic [ADDR_W:0]   len;
    logic [POS_W-1:0]  head_pos;
    logic              full;

    snake_body_buffer_if #(.POS_W(POS_W), .ADDR_W(ADDR_W)) bus ();

    snake_body_buffer #(
        .POS_W (POS_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .init    (init),
        .init_pos(init_pos),
        .bus     (bus),
        .len     (len),
        .head_pos(head_pos),
        .full    (full)
    );

    typedef struct {
        bit                do_init;
        logic [POS_W-1:0]  ipos;
        bit                sv;
        bit                grow;
        logic [POS_W-1:0]  spos;
        bit                rd;
        logic [ADDR_W-1:0] idx;
        logic [POS_W-1:0]  exp_rd;
        int                exp_len;
        logic [POS_W-1:0]  exp_head;
    } vec_t;

    typedef struct {
        logic [POS_W-1:0] data;
        int               due;
    } rd_exp_t;

    vec_t             tbl [14];
    rd_exp_t          exp_rd_q [$];
    logic [POS_W-1:0] model_q [$];
    int               n_vectors     = 0;
    int               n_miscompares = 0;
    int               cyc           = 0;
    bit               saw_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to time-stamp expected read results
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [POS_W-1:0] model_read(input int idx);
        if (idx < model_q.size()) return model_q[idx];
        return '0;
    endfunction

    // Read scoreboard: a due entry needs rd_valid and matching data, otherwise rd_valid must be low
    always @(negedge clk) begin
        if (exp_rd_q.size() > 0 && exp_rd_q[0].due == cyc) begin
            if (bus.rd_valid !== 1'b1) begin
                n_vectors++;
                n_miscompares++;
                $display("[TB] FAIL rd_valid_missing: got %b, expected 1 (t=%0t)", bus.rd_valid, $time);
            end else begin
                check_output("rd_data", 32'(bus.rd_data), 32'(exp_rd_q[0].data));
            end
            exp_rd_q.delete(0);
        end else begin
            check_output("rd_valid_idle", 32'(bus.rd_valid), 32'(0));
        end
    end

    // Drives one cycle of step/read/init stimulus just after an edge and updates the model
    task automatic apply_stimulus(input bit do_init, input logic [POS_W-1:0] ipos,
                                  input bit sv, input bit grow, input logic [POS_W-1:0] spos,
                                  input bit rd, input logic [ADDR_W-1:0] idx,
                                  input logic [POS_W-1:0] exp_rd);
        rd_exp_t e;
        init           = do_init;
        init_pos       = ipos;
        bus.step_valid = sv;
        bus.step_grow  = grow;
        bus.step_pos   = spos;
        bus.rd_en      = rd;
        bus.rd_idx     = idx;
        if (rd) begin
            e.data = exp_rd;
            e.due  = cyc + 1;
            exp_rd_q.push_back(e);
        end
        #1;
        check_output("step_ready", 32'(bus.step_ready), 32'(!do_init));
        if (do_init) begin
            model_q = {ipos};
        end else if (sv) begin
            model_q.push_front(spos);
            if (!grow || model_q.size() > DEPTH) model_q.delete(model_q.size() - 1);
        end
        @(posedge clk);
        #1;
        init           = 1'b0;
        bus.step_valid = 1'b0;
        bus.step_grow  = 1'b0;
        bus.rd_en      = 1'b0;
        bus.scan_start = 1'b0;
    endtask

`ifdef SNAKE_BUF_SCAN_EN
    // Runs one query, tries a step while busy, and checks done latency and the held hit flag
    task automatic run_scan(input string tag, input logic [POS_W-1:0] pos, input bit skip,
                            input int exp_done, input bit exp_hit);
        int c;
        int done_at;
        bus.scan_start     = 1'b1;
        bus.scan_pos       = pos;
        bus.scan_skip_head = skip;
        @(posedge clk);
        #1;
        bus.scan_start = 1'b0;
        c       = 1;
        done_at = 0;
        check_output({tag, "_busy"}, 32'(bus.scan_busy), 32'(1));
        check_output({tag, "_ready"}, 32'(bus.step_ready), 32'(0));
        bus.step_valid = 1'b1;
        bus.step_grow  = 1'b1;
        bus.step_pos   = 12'hFFF;
        while (c <= 20 && done_at == 0) begin
            if (bus.scan_done === 1'b1) begin
                done_at = c;
            end else begin
                @(posedge clk);
                #1;
                c++;
                if (c == 2) begin
                    bus.step_valid = 1'b0;
                    check_output({tag, "_len_blocked"}, 32'(len), 32'(model_q.size()));
                    check_output({tag, "_head_blocked"}, 32'(head_pos), 32'(model_q[0]));
                end
            end
        end
        bus.step_valid = 1'b0;
        check_output({tag, "_done_cycle"}, 32'(done_at), 32'(exp_done));
        check_output({tag, "_hit"}, 32'(bus.scan_hit), 32'(exp_hit));
        @(posedge clk);
        #1;
        check_output({tag, "_done_pulse"}, 32'(bus.scan_done), 32'(0));
        check_output({tag, "_idle"}, 32'(bus.scan_busy), 32'(0));
        check_output({tag, "_hit_held"}, 32'(bus.scan_hit), 32'(exp_hit));
    endtask
`endif

    initial begin
        // Fields: init, init_pos, step_valid, grow, step_pos, rd_en, rd_idx, exp_rd, exp_len, exp_head
        tbl[0]  = '{1'b1, 12'h123, 1'b0, 1'b0, 12'h000, 1'b0, 7'd0, 12'h000, 1, 12'h123};
        tbl[1]  = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b1, 7'd0, 12'h123, 1, 12'h123};
        tbl[2]  = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b1, 7'd1, 12'h000, 1, 12'h123};
        tbl[3]  = '{1'b0, 12'h000, 1'b1, 1'b1, 12'h001, 1'b1, 7'd0, 12'h123, 2, 12'h001};
        tbl[4]  = '{1'b0, 12'h000, 1'b1, 1'b1, 12'h002, 1'b0, 7'd0, 12'h000, 3, 12'h002};
        tbl[5]  = '{1'b0, 12'h000, 1'b1, 1'b1, 12'h003, 1'b0, 7'd0, 12'h000, 4, 12'h003};
        tbl[6]  = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b1, 7'd0, 12'h003, 4, 12'h003};
        tbl[7]  = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b1, 7'd1, 12'h002, 4, 12'h003};
        tbl[8]  = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b1, 7'd2, 12'h001, 4, 12'h003};
        tbl[9]  = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b1, 7'd3, 12'h123, 4, 12'h003};
        tbl[10] = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h004, 1'b1, 7'd3, 12'h123, 4, 12'h004};
        tbl[11] = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b1, 7'd3, 12'h001, 4, 12'h004};
        tbl[12] = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b1, 7'd4, 12'h000, 4, 12'h004};
        tbl[13] = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b1, 7'd0, 12'h004, 4, 12'h004};

        reset_n            = 1'b0;
        init               = 1'b0;
        init_pos           = '0;
        bus.step_valid     = 1'b0;
        bus.step_grow      = 1'b0;
        bus.step_pos       = '0;
        bus.rd_en          = 1'b0;
        bus.rd_idx         = '0;
        bus.scan_start     = 1'b0;
        bus.scan_pos       = '0;
        bus.scan_skip_head = 1'b0;
        model_q            = {12'h000};

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_output("rst_len", 32'(len), 32'(1));
        check_output("rst_head", 32'(head_pos), 32'(0));
        check_output("rst_full", 32'(full), 32'(0));
        check_output("rst_rd_data", 32'(bus.rd_data), 32'(0));
        check_output("rst_step_ready", 32'(bus.step_ready), 32'(1));
        check_output("rst_scan_busy", 32'(bus.scan_busy), 32'(0));
        check_output("rst_scan_done", 32'(bus.scan_done), 32'(0));
        check_output("rst_scan_hit", 32'(bus.scan_hit), 32'(0));

        for (int i = 0; i < 14; i++) begin
            apply_stimulus(tbl[i].do_init, tbl[i].ipos, tbl[i].sv, tbl[i].grow, tbl[i].spos,
                           tbl[i].rd, tbl[i].idx, tbl[i].exp_rd);
            check_output($sformatf("vec%0d_len", i), 32'(len), 32'(tbl[i].exp_len));
            check_output($sformatf("vec%0d_head", i), 32'(head_pos), 32'(tbl[i].exp_head));
            check_output($sformatf("vec%0d_full", i), 32'(full), 32'(0));
        end

        // Fill to DEPTH, then keep growing so the head pointer wraps and length saturates
        for (int k = 0; k < 324; k++) begin
            apply_stimulus(1'b0, '0, 1'b1, 1'b1, 12'(12'h200 + k), 1'b0, '0, '0);
            check_output("fill_len", 32'(len), 32'(model_q.size()));
            check_output("fill_full", 32'(full), 32'(model_q.size() == DEPTH));
            check_output("fill_head", 32'(head_pos), 32'(model_q[0]));
        end
        check_output("full_len", 32'(len), 32'(128));
        check_output("full_flag", 32'(full), 32'(1));
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 7'd127, 12'h2C4);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 7'd0, 12'h343);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 7'd64, model_read(64));
        apply_stimulus(1'b0, '0, 1'b1, 1'b0, 12'h3AA, 1'b1, 7'd127, model_read(127));
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 7'd127, model_read(127));
        check_output("full_move_len", 32'(len), 32'(128));

        // Back to a four-segment body: 3, 2, 1, 123
        apply_stimulus(1'b1, 12'h123, 1'b0, 1'b0, '0, 1'b0, '0, '0);
        apply_stimulus(1'b0, '0, 1'b1, 1'b1, 12'h001, 1'b0, '0, '0);
        apply_stimulus(1'b0, '0, 1'b1, 1'b1, 12'h002, 1'b0, '0, '0);
        apply_stimulus(1'b0, '0, 1'b1, 1'b1, 12'h003, 1'b0, '0, '0);
        check_output("reinit_len", 32'(len), 32'(4));

`ifdef SNAKE_BUF_SCAN_EN
        run_scan("scan_hit_idx2", 12'h001, 1'b1, 4, 1'b1);
        run_scan("scan_absent", 12'hABC, 1'b1, 5, 1'b0);
        run_scan("scan_head", 12'h003, 1'b0, 3, 1'b1);
        apply_stimulus(1'b1, 12'h055, 1'b0, 1'b0, '0, 1'b0, '0, '0);
        check_output("init_clears_hit", 32'(bus.scan_hit), 32'(0));
        run_scan("scan_empty", 12'h055, 1'b1, 2, 1'b0);

        apply_stimulus(1'b0, '0, 1'b1, 1'b1, 12'h001, 1'b0, '0, '0);
        apply_stimulus(1'b0, '0, 1'b1, 1'b1, 12'h002, 1'b0, '0, '0);
        apply_stimulus(1'b0, '0, 1'b1, 1'b1, 12'h003, 1'b0, '0, '0);
        bus.scan_start     = 1'b1;
        bus.scan_pos       = 12'h055;
        bus.scan_skip_head = 1'b1;
        @(posedge clk);
        #1;
        bus.scan_start = 1'b0;
        @(posedge clk);
        #1;
        init     = 1'b1;
        init_pos = 12'h077;
        #1;
        check_output("abort_ready", 32'(bus.step_ready), 32'(0));
        @(posedge clk);
        #1;
        init    = 1'b0;
        model_q = {12'h077};
        check_output("abort_busy", 32'(bus.scan_busy), 32'(0));
        check_output("abort_hit", 32'(bus.scan_hit), 32'(0));
        check_output("abort_len", 32'(len), 32'(1));
        check_output("abort_head", 32'(head_pos), 32'(12'h077));
        saw_done = 1'b0;
        repeat (8) begin
            if (bus.scan_done !== 1'b0) saw_done = 1'b1;
            @(posedge clk);
            #1;
        end
        check_output("abort_no_done", 32'(saw_done), 32'(0));
`else
        bus.scan_start     = 1'b1;
        bus.scan_pos       = 12'h003;
        bus.scan_skip_head = 1'b0;
        apply_stimulus(1'b0, '0, 1'b1, 1'b1, 12'h00A, 1'b0, '0, '0);
        check_output("noscan_len", 32'(len), 32'(model_q.size()));
        check_output("noscan_head", 32'(head_pos), 32'(12'h00A));
        repeat (3) begin
            check_output("noscan_busy", 32'(bus.scan_busy), 32'(0));
            check_output("noscan_done", 32'(bus.scan_done), 32'(0));
            check_output("noscan_hit", 32'(bus.scan_hit), 32'(0));
            check_output("noscan_ready", 32'(bus.step_ready), 32'(1));
            @(posedge clk);
            #1;
        end
`endif

        // Asynchronous reset in the middle of activity
        apply_stimulus(1'b0, '0, 1'b1, 1'b1, 12'h0B1, 1'b0, '0, '0);
        apply_stimulus(1'b0, '0, 1'b1, 1'b1, 12'h0B2, 1'b0, '0, '0);
        check_output("pre_reset_len", 32'(len), 32'(model_q.size()));
`ifdef SNAKE_BUF_SCAN_EN
        bus.scan_start     = 1'b1;
        bus.scan_pos       = 12'hABC;
        bus.scan_skip_head = 1'b0;
        @(posedge clk);
        #1;
        bus.scan_start = 1'b0;
`endif
        reset_n = 1'b0;
        #1;
        check_output("arst_len", 32'(len), 32'(1));
        check_output("arst_head", 32'(head_pos), 32'(0));
        check_output("arst_full", 32'(full), 32'(0));
        check_output("arst_busy", 32'(bus.scan_busy), 32'(0));
        check_output("arst_ready", 32'(bus.step_ready), 32'(1));
        @(negedge clk);
        reset_n = 1'b1;
        model_q = {12'h000};
        @(posedge clk);
        #1;
        check_output("post_reset_len", 32'(len), 32'(1));
        check_output("post_reset_done", 32'(bus.scan_done), 32'(0));
        @(posedge clk);
        #1;
        check_output("rd_queue_drained", 32'(exp_rd_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
